// File: rtl/dot_mac8_if.sv
// ============================================================================
//  Module : dot_mac8_if
//  Brief  : Bus bundle for dot_mac8. It carries the operand stream, the port
//           to the external sequential multiplier, the result stream and the
//           error flag.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dot_mac8_if;
  // operand stream
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        in_last;
  // sequential multiplier port
  logic [7:0]  mul_x;
  logic [7:0]  mul_y;
  logic        mul_start;
  logic        mul_done;
  logic [15:0] mul_r;
  // result stream
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic [8:0]  out_count;
  logic        err;

  // environment side: the operand producer, the multiplier and the result consumer
  modport master (
    output in_valid, a, b, in_last, mul_done, mul_r, out_ready,
    input  in_ready, mul_x, mul_y, mul_start, out_valid, out_sum, out_count, err
  );

  // accumulator side
  modport slave (
    input  in_valid, a, b, in_last, mul_done, mul_r, out_ready,
    output in_ready, mul_x, mul_y, mul_start, out_valid, out_sum, out_count, err
  );
endinterface

`default_nettype wire

// File: rtl/dot_mac8.sv
// ============================================================================
//  Module : dot_mac8
//  Brief  : Unsigned 8-bit dot-product accumulator. Each accepted operand pair
//           is multiplied by an external sequential multiplier, and the
//           product is added into a 24-bit accumulator. A result is emitted
//           on in_last or after MAX_TERMS terms. A multiplier that never
//           answers sets a sticky err flag, and that term adds nothing.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dot_mac8 #(
  parameter int MAX_WAIT  = 30,
  parameter int MAX_TERMS = 256
) (
  input  wire logic   clk,
  input  wire logic   rst,
  dot_mac8_if.slave   bus
);

  localparam int          c_WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);
  localparam [8:0]        c_TERMS_MAX = 9'(MAX_TERMS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    EMIT    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_mul_x;
  logic [7:0]          r_mul_y;
  logic                r_last;
  logic [8:0]          r_cnt;
  logic [23:0]         r_acc;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_err;

  logic w_accept;
  logic w_timeout;
  logic w_close;

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  // The last allowed ISSUE cycle has passed without an answer. A late
  // mul_done on that same edge still wins.
  assign w_timeout = (r_state == ISSUE) && !bus.mul_done && (r_wait == c_WAIT_LAST);
  // The product closes on an explicit last term or when the term budget is used up.
  assign w_close   = r_last || (r_cnt == c_TERMS_MAX);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ISSUE;
      ISSUE:   if (bus.mul_done || w_timeout) w_next = RELEASE;
      RELEASE: if (!bus.mul_done) w_next = w_close ? EMIT : IDLE;
      EMIT:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, term count, wait timer, accumulation and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mul_x <= 8'd0;
      r_mul_y <= 8'd0;
      r_last  <= 1'b0;
      r_cnt   <= 9'd0;
      r_acc   <= 24'd0;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mul_x <= bus.a;
            r_mul_y <= bus.b;
            r_last  <= bus.in_last;
            r_cnt   <= r_cnt + 9'd1;
            r_wait  <= '0;
          end
        end
        ISSUE: begin
          if (bus.mul_done) r_acc  <= r_acc + {8'd0, bus.mul_r};
          else if (w_timeout) r_err <= 1'b1;
          else r_wait <= r_wait + 1'b1;
        end
        EMIT: begin
          if (bus.out_ready) begin
            r_acc <= 24'd0;
            r_cnt <= 9'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from registered state only, so they hold steady within a state
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.mul_start = (r_state == ISSUE);
  assign bus.mul_x     = r_mul_x;
  assign bus.mul_y     = r_mul_y;
  assign bus.out_valid = (r_state == EMIT);
  assign bus.out_sum   = r_acc;
  assign bus.out_count = r_cnt;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dot_mac8.sv
// ============================================================================
//  Module : tb_dot_mac8
//  Brief  : Directed self-checking bench for dot_mac8 with a behavioural
//           sequential multiplier that can be made to hang.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dot_mac8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  bit   mul_hang;
  int   mul_lat;
  int   mcnt;

  dot_mac8_if mif ();

  dot_mac8 #(.MAX_WAIT(30), .MAX_TERMS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: answer mul_lat+1 cycles after start and hold done until start drops
  always @(negedge clk) begin
    if (mif.mul_start !== 1'b1) begin
      mif.mul_done = 1'b0;
      mcnt = 0;
    end else if (!mul_hang && !mif.mul_done) begin
      if (mcnt >= mul_lat) begin
        mif.mul_done = 1'b1;
        mif.mul_r    = 16'(mif.mul_x) * 16'(mif.mul_y);
      end else begin
        mcnt = mcnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one pair and hold it until the block takes it
  task automatic send(input string tag, input logic [7:0] x, input logic [7:0] y, input logic last);
    int n;
    n = 0;
    mif.in_valid = 1'b1;
    mif.a        = x;
    mif.b        = y;
    mif.in_last  = last;
    while (mif.in_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(mif.in_ready), 32'd1);
    @(negedge clk);
    mif.in_valid = 1'b0;
  endtask

  // Wait for a result, compare it, take it and confirm out_valid drops
  task automatic wait_out(input string tag, input logic [23:0] es, input logic [8:0] ec);
    int n;
    n = 0;
    while (mif.out_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(mif.out_valid), 32'd1);
    check({tag, "_sum"},   32'(mif.out_sum),   32'(es));
    check({tag, "_count"}, 32'(mif.out_count), 32'(ec));
    mif.out_ready = 1'b1;
    @(negedge clk);
    mif.out_ready = 1'b0;
    check({tag, "_drop"}, 32'(mif.out_valid), 32'd0);
  endtask

  initial begin
    int n;
    n_checks      = 0;
    n_errors      = 0;
    mul_hang      = 1'b0;
    mul_lat       = 2;
    mcnt          = 0;
    rst           = 1'b0;
    mif.in_valid  = 1'b0;
    mif.a         = 8'd0;
    mif.b         = 8'd0;
    mif.in_last   = 1'b0;
    mif.mul_done  = 1'b0;
    mif.mul_r     = 16'd0;
    mif.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  32'(mif.in_ready),  32'd1);
    check("rst_out_valid", 32'(mif.out_valid), 32'd0);
    check("rst_mul_start", 32'(mif.mul_start), 32'd0);
    check("rst_mul_x",     32'(mif.mul_x),     32'd0);
    check("rst_out_sum",   32'(mif.out_sum),   32'd0);
    check("rst_out_count", 32'(mif.out_count), 32'd0);
    check("rst_err",       32'(mif.err),       32'd0);

    // Single maximal term: 0xFF*0xFF = 0xFE01
    send("one", 8'hFF, 8'hFF, 1'b1);
    wait_out("one", 24'h00FE01, 9'd1);

    // Four terms: 6 + 20 + 256 + 0 = 282
    send("four0", 8'd2,   8'd3,   1'b0);
    send("four1", 8'd4,   8'd5,   1'b0);
    send("four2", 8'h10,  8'h10,  1'b0);
    send("four3", 8'h00,  8'hAB,  1'b1);
    wait_out("four", 24'h00011A, 9'd4);

    // Back-pressure: the result stays put and a waiting pair is not taken
    send("hold", 8'd1, 8'd2, 1'b1);
    n = 0;
    while (mif.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid", 32'(mif.out_valid), 32'd1);
    mif.in_valid = 1'b1;
    mif.a        = 8'd7;
    mif.b        = 8'd7;
    mif.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_sum",      32'(mif.out_sum),   32'd2);
      check("hold_count",    32'(mif.out_count), 32'd1);
      check("hold_in_ready", 32'(mif.in_ready),  32'd0);
    end
    mif.out_ready = 1'b1;
    @(negedge clk);
    mif.out_ready = 1'b0;
    check("hold_drop", 32'(mif.out_valid), 32'd0);
    @(negedge clk);
    mif.in_valid = 1'b0;
    wait_out("hold_next", 24'd49, 9'd1);

    // Term budget: 256 * 0xFE01 = 0xFE0100 closes without in_last
    mul_lat = 0;
    for (int i = 0; i < 256; i++) send("max", 8'hFF, 8'hFF, 1'b0);
    wait_out("max", 24'hFE0100, 9'd256);
    send("after_max", 8'd3, 8'd4, 1'b1);
    wait_out("after_max", 24'd12, 9'd1);
    mul_lat = 2;

    // Multiplier timeout: err sets on the 30th ISSUE cycle and the term adds nothing
    mul_hang = 1'b1;
    send("to", 8'd5, 8'd5, 1'b1);
    repeat (29) @(negedge clk);
    check("to_in_issue", 32'(mif.mul_start), 32'd1);
    check("to_err_early", 32'(mif.err), 32'd0);
    @(negedge clk);
    check("to_err_set", 32'(mif.err), 32'd1);
    wait_out("to", 24'd0, 9'd1);
    mul_hang = 1'b0;
    send("to_next", 8'd2, 8'd2, 1'b1);
    wait_out("to_next", 24'd4, 9'd1);
    check("to_err_sticky", 32'(mif.err), 32'd1);

    // Reset while the second term is in ISSUE discards everything
    send("rs0", 8'd1, 8'd1, 1'b0);
    n = 0;
    while (mif.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    mul_hang = 1'b1;
    send("rs1", 8'd2, 8'd2, 1'b0);
    repeat (3) @(negedge clk);
    check("rs_in_issue", 32'(mif.mul_start), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rs_mul_start", 32'(mif.mul_start), 32'd0);
    check("rs_mul_x",     32'(mif.mul_x),     32'd0);
    check("rs_mul_y",     32'(mif.mul_y),     32'd0);
    check("rs_out_valid", 32'(mif.out_valid), 32'd0);
    check("rs_out_sum",   32'(mif.out_sum),   32'd0);
    check("rs_out_count", 32'(mif.out_count), 32'd0);
    check("rs_err",       32'(mif.err),       32'd0);
    @(negedge clk);
    rst      = 1'b1;
    mul_hang = 1'b0;
    @(negedge clk);
    check("rs_in_ready", 32'(mif.in_ready), 32'd1);
    send("rs_next", 8'd3, 8'd3, 1'b1);
    wait_out("rs_next", 24'd9, 9'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
